// File: rtl/component_alu_seq.sv
// component_alu_seq: sequential ALU with a valid/ready handshake on both sides.
// Logic, add/sub and shift operations finish one cycle after acceptance.
// MUL (shift-add) and DIVU/REMU (restoring division) take WIDTH iteration
// cycles in BUSY. The result and flags are held in DONE until the consumer
// takes them.
//
// Ports:
//   input_Clock, input_ResetN          clock, synchronous active-low reset
//   input_Valid / output_Ready         request handshake (Ready only in IDLE)
//   input_A, input_B, input_Func       operands and operation select
//   output_Valid / input_Ready         result handshake
//   output_Result                      registered result
//   output_ZeroFlag, output_CarryFlag, output_NegativeFlag,
//   output_OverflowFlag, output_DivZeroFlag, output_Illegal   registered flags
module component_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             input_Clock,
    input  logic             input_ResetN,
    input  logic             input_Valid,
    output logic             output_Ready,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [3:0]       input_Func,
    output logic             output_Valid,
    input  logic             input_Ready,
    output logic [WIDTH-1:0] output_Result,
    output logic             output_ZeroFlag,
    output logic             output_CarryFlag,
    output logic             output_NegativeFlag,
    output logic             output_OverflowFlag,
    output logic             output_DivZeroFlag,
    output logic             output_Illegal
);

    localparam logic [3:0] F_AND  = 4'd0;
    localparam logic [3:0] F_OR   = 4'd1;
    localparam logic [3:0] F_XOR  = 4'd2;
    localparam logic [3:0] F_ADD  = 4'd3;
    localparam logic [3:0] F_SUB  = 4'd4;
    localparam logic [3:0] F_SLL  = 4'd5;
    localparam logic [3:0] F_SRL  = 4'd6;
    localparam logic [3:0] F_SRA  = 4'd7;
    localparam logic [3:0] F_MUL  = 4'd8;
    localparam logic [3:0] F_DIVU = 4'd9;
    localparam logic [3:0] F_REMU = 4'd10;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic             accept;
    logic             multi_cycle;

    // Iterative datapath: acc is the product accumulator (MUL) or partial
    // remainder (DIVU/REMU); opa is the shifted multiplicand or the
    // dividend/quotient shift register; opb is the multiplier or divisor.
    logic [WIDTH-1:0] acc, opa, opb;
    logic [3:0]       func_r;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] acc_it, opa_it, opb_it;
    logic [WIDTH:0]   trial, trial_diff;
    logic [WIDTH-1:0] iter_res;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   alu_sum;
    logic             alu_c, alu_v, alu_ill;
    logic [SHW-1:0]   shamt;

    assign output_Ready = (state == IDLE);
    assign output_Valid = (state == DONE);
    assign accept       = input_Valid && output_Ready;
    assign multi_cycle  = (input_Func == F_MUL) || (input_Func == F_DIVU) ||
                          (input_Func == F_REMU);
    assign shamt        = input_B[SHW-1:0];

    always_ff @(posedge input_Clock) begin
        if (!input_ResetN) state <= IDLE;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = multi_cycle ? BUSY : DONE;
            BUSY: if (cnt == LAST_ITER) state_nxt = DONE;
            DONE: if (input_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle operations, computed straight from the inputs so the
    // result register is loaded on the accept edge.
    always_comb begin
        alu_res = '0;
        alu_sum = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (input_Func)
            F_AND: alu_res = input_A & input_B;
            F_OR:  alu_res = input_A | input_B;
            F_XOR: alu_res = input_A ^ input_B;
            F_ADD: begin
                alu_sum = {1'b0, input_A} + {1'b0, input_B};
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (input_A[WIDTH-1] == input_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != input_A[WIDTH-1]);
            end
            F_SUB: begin
                alu_res = input_A - input_B;
                alu_c   = (input_A < input_B);
                alu_v   = (input_A[WIDTH-1] != input_B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != input_A[WIDTH-1]);
            end
            F_SLL: alu_res = input_A << shamt;
            F_SRL: alu_res = input_A >> shamt;
            F_SRA: alu_res = WIDTH'($signed(input_A) >>> shamt);
            F_MUL, F_DIVU, F_REMU: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One iteration step. With a zero divisor every trial subtraction
    // succeeds, so the quotient fills with ones and the remainder ends
    // up equal to A without any special casing.
    always_comb begin
        acc_it     = acc;
        opa_it     = opa;
        opb_it     = opb;
        trial      = '0;
        trial_diff = '0;
        if (func_r == F_MUL) begin
            if (opb[0]) acc_it = acc + opa;
            opa_it = opa << 1;
            opb_it = opb >> 1;
        end else begin
            trial      = {acc, opa[WIDTH-1]};
            trial_diff = trial - {1'b0, opb};
            if (trial >= {1'b0, opb}) begin
                acc_it = trial_diff[WIDTH-1:0];
                opa_it = {opa[WIDTH-2:0], 1'b1};
            end else begin
                acc_it = trial[WIDTH-1:0];
                opa_it = {opa[WIDTH-2:0], 1'b0};
            end
        end
        iter_res = (func_r == F_DIVU) ? opa_it : acc_it;
    end

    always_ff @(posedge input_Clock) begin
        if (state == IDLE && accept) begin
            acc    <= '0;
            opa    <= input_A;
            opb    <= input_B;
            func_r <= input_Func;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc <= acc_it;
            opa <= opa_it;
            opb <= opb_it;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge input_Clock) begin
        if (!input_ResetN) begin
            output_Result       <= '0;
            output_ZeroFlag     <= 1'b0;
            output_CarryFlag    <= 1'b0;
            output_NegativeFlag <= 1'b0;
            output_OverflowFlag <= 1'b0;
            output_DivZeroFlag  <= 1'b0;
            output_Illegal      <= 1'b0;
        end else if (state == IDLE && accept && !multi_cycle) begin
            output_Result       <= alu_res;
            output_ZeroFlag     <= (alu_res == '0);
            output_CarryFlag    <= alu_c;
            output_NegativeFlag <= alu_res[WIDTH-1];
            output_OverflowFlag <= alu_v;
            output_DivZeroFlag  <= 1'b0;
            output_Illegal      <= alu_ill;
        end else if (state == BUSY && cnt == LAST_ITER) begin
            output_Result       <= iter_res;
            output_ZeroFlag     <= (iter_res == '0);
            output_CarryFlag    <= 1'b0;
            output_NegativeFlag <= iter_res[WIDTH-1];
            output_OverflowFlag <= 1'b0;
            // opb still holds the divisor here; it is only shifted for MUL
            output_DivZeroFlag  <= (func_r != F_MUL) && (opb == '0);
            output_Illegal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_component_alu_seq.sv
module tb_component_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       func;
    logic             out_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             zf, cf, nf, vf, dzf, ill;

    int n_total = 0;
    int n_pass  = 0;

    component_alu_seq #(.WIDTH(WIDTH)) dut (
        .input_Clock         (clk),
        .input_ResetN        (rst_n),
        .input_Valid         (in_valid),
        .output_Ready        (out_ready),
        .input_A             (a),
        .input_B             (b),
        .input_Func          (func),
        .output_Valid        (out_valid),
        .input_Ready         (in_ready),
        .output_Result       (result),
        .output_ZeroFlag     (zf),
        .output_CarryFlag    (cf),
        .output_NegativeFlag (nf),
        .output_OverflowFlag (vf),
        .output_DivZeroFlag  (dzf),
        .output_Illegal      (ill)
    );

    always #5 clk = ~clk;

    // flags packed as {Z, C, N, V, DZ, ILL}
    function automatic logic [5:0] flags();
        return {zf, cf, nf, vf, dzf, ill};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, then count edges (accept edge = 1) until
    // output_Valid is seen; ready must stay low while waiting.
    task automatic run_op(input logic [3:0] f, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, output int lat,
                          output bit rdy_low);
        func = f; a = av; b = bv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            if (out_ready) rdy_low = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] f,
                         input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] exp_res, input logic [5:0] exp_fl,
                         input int exp_lat);
        int lat;
        bit rdy_low;
        run_op(f, av, bv, lat, rdy_low);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_flags"}, flags(), exp_fl);
        if (exp_lat > 1) chk({tag, "_rdy_busy"}, rdy_low, 1'b1);
        consume();
        chk({tag, "_idle"}, {out_valid, out_ready}, 2'b01);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        a = '0; b = '0; func = '0;
        tick(); tick();
        chk("rst_res", result, 0);
        chk("rst_flags", flags(), 6'b000000);
        chk("rst_hs", {out_valid, out_ready}, 2'b01);
        rst_n = 1'b1;

        //            tag       func   A             B             result        ZCNVDI     lat
        do_op("add_wrap", 4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 6'b110000, 1);
        do_op("add_ovf",  4'd3,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 6'b001100, 1);
        do_op("sub_ovf",  4'd4,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 6'b000100, 1);
        do_op("sub_brw",  4'd4,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 6'b011000, 1);
        do_op("and",      4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 6'b001000, 1);
        do_op("or",       4'd1,  32'h0000000F, 32'h000000F0, 32'h000000FF, 6'b000000, 1);
        do_op("xor",      4'd2,  32'h00000005, 32'h00000005, 32'h00000000, 6'b100000, 1);
        do_op("sll_hib",  4'd5,  32'h00000001, 32'h00000124, 32'h00000010, 6'b000000, 1);
        do_op("srl",      4'd6,  32'h80000000, 32'h0000001F, 32'h00000001, 6'b000000, 1);
        do_op("mul",      4'd8,  32'h00010000, 32'h00010003, 32'h00030000, 6'b000000, 33);
        do_op("divu",     4'd9,  32'd100,      32'd7,        32'd14,       6'b000000, 33);
        do_op("remu",     4'd10, 32'd100,      32'd7,        32'd2,        6'b000000, 33);
        do_op("divu_z",   4'd9,  32'd5,        32'd0,        32'hFFFFFFFF, 6'b001010, 33);
        do_op("remu_z",   4'd10, 32'd5,        32'd0,        32'd5,        6'b000010, 33);
        do_op("illegal",  4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 6'b100001, 1);

        // Backpressure: result held in DONE while new requests are ignored.
        begin
            int lat;
            bit rdy_low;
            run_op(4'd3, 32'd2, 32'd3, lat, rdy_low);
            chk("bp_lat", lat, 1);
            func = 4'd4; a = 32'd9; b = 32'd9; in_valid = 1'b1;
            for (int i = 0; i < 5; i++) tick();
            chk("bp_res", result, 32'd5);
            chk("bp_flags", flags(), 6'b000000);
            chk("bp_hs", {out_valid, out_ready}, 2'b10);
            in_valid = 1'b0;
            consume();
            chk("bp_idle", {out_valid, out_ready}, 2'b01);
            chk("bp_nocap", result, 32'd5);
        end

        // Reset in the middle of a division discards it.
        func = 4'd9; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy", {out_valid, out_ready}, 2'b00);
        rst_n = 1'b0;
        tick();
        chk("abort_hs", {out_valid, out_ready}, 2'b01);
        chk("abort_res", result, 0);
        chk("abort_flags", flags(), 6'b000000);
        rst_n = 1'b1;
        do_op("sra", 4'd7, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 6'b001000, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
